// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and DM region constants for the memory-port sequencer.
// The DM is one byte array: instruction region first, data region after it.
package mem_port_ctrl_pkg;

  typedef enum logic [1:0] {
    ReqFetch   = 2'b00,
    ReqLoad    = 2'b01,
    ReqStore   = 2'b10,
    ReqIllegal = 2'b11
  } req_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StWrite,
    StDone,
    StErr
  } state_e;

  localparam int unsigned ImemRegionBytes = 32;
  localparam int unsigned DmTotalBytes    = 96;
  localparam int unsigned DmemRegionBytes = DmTotalBytes - ImemRegionBytes;
  localparam int unsigned CntW            = 4;

  function automatic logic is_word_aligned(logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_addr_map.sv
// Classifies a request (misaligned / out of range / illegal) and produces the
// DM address and IorD select it should be issued with.
module mem_addr_map
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned ImemBytes = ImemRegionBytes,
  parameter int unsigned DmemBytes = DmemRegionBytes
) (
  input  req_type_e   req_type,
  input  logic [31:0] req_addr,
  output logic        bad,
  output logic [31:0] map_addr,
  output logic        map_iord
);

  always_comb begin
    bad      = !is_word_aligned(req_addr);
    map_addr = req_addr;
    map_iord = 1'b0;
    case (req_type)
      ReqFetch: begin
        bad      = bad | (req_addr >= 32'(ImemBytes));
        map_addr = req_addr >> 2;
        map_iord = 1'b1;
      end
      ReqLoad: begin
        bad = bad | (req_addr >= 32'(DmemBytes));
      end
      ReqStore: begin
        // Writes use the DM's word index over the whole array.
        bad      = bad | (req_addr >= 32'(DmemBytes));
        map_addr = (32'(ImemBytes) + req_addr) >> 2;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-access sequencer between the multi-cycle control unit and the DM:
// accepts fetch/load/store requests and drives the DM strobes for them.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned WaitCycles = 1,
  parameter int unsigned ImemBytes  = ImemRegionBytes,
  parameter int unsigned DmemBytes  = DmemRegionBytes
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] ir_out,
  output logic [31:0] mdr_out,
  output logic        dm_r,
  output logic        dm_w,
  output logic        dm_iord,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [CntW-1:0] WaitLoad = CntW'(WaitCycles);

  state_e          state_q;
  req_type_e       type_q;
  logic [CntW-1:0] cnt_q;

  logic        map_bad;
  logic        map_iord;
  logic [31:0] map_addr;

  mem_addr_map #(
    .ImemBytes(ImemBytes),
    .DmemBytes(DmemBytes)
  ) u_addr_map (
    .req_type(req_type_e'(req_type)),
    .req_addr(req_addr),
    .bad     (map_bad),
    .map_addr(map_addr),
    .map_iord(map_iord)
  );

  assign req_ready = (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      type_q   <= ReqFetch;
      cnt_q    <= '0;
      ir_out   <= '0;
      mdr_out  <= '0;
      dm_r     <= 1'b0;
      dm_w     <= 1'b0;
      dm_iord  <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            type_q <= req_type_e'(req_type);
            if (map_bad) begin
              // Rejected requests never disturb the DM address or strobes.
              state_q <= StErr;
              err     <= 1'b1;
            end else begin
              dm_addr <= map_addr;
              dm_iord <= map_iord;
              if (req_type_e'(req_type) == ReqStore) begin
                state_q  <= StWrite;
                dm_w     <= 1'b1;
                dm_wdata <= req_wdata;
              end else begin
                state_q <= StAccess;
                dm_r    <= 1'b1;
                cnt_q   <= WaitLoad;
              end
            end
          end
        end
        StAccess: begin
          if (cnt_q == CntW'(1)) begin
            dm_r    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
            if (type_q == ReqFetch) begin
              ir_out <= dm_rdata;
            end else begin
              mdr_out <= dm_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StWrite: begin
          dm_w    <= 1'b0;
          done    <= 1'b1;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
